// File: rtl/pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// pipeline_control_unit
//
// Control path of the 5-stage processor. Decodes the instruction held in the
// IF/ID register, carries its control bundle and destination tag through the
// ID/EX, EX/MEM and MEM/WB registers, and raises stall/flush for hazards.
// The datapath stage registers hold the data values; this block only holds
// control bits and register tags.
//
// Optional feature macro: FWD_EN
//   defined   : adds fwd_a / fwd_b operand-forwarding selects; only the
//               load-use hazard stalls.
//   undefined : no forwarding; any ID source matching a writing destination
//               in EX or MEM stalls until the producer reaches WB.
//
// Ports
//   clock, reset_n       rising-edge clock, asynchronous active-low reset
//   id_valid             IF/ID holds a real instruction
//   opcode, raw_aluop    ID opcode and R-type ALU op field
//   rd, rs, rt           ID register fields
//   branch_taken         EX branch/jump redirects the PC (drives flush)
//   ex_ovf               EX ALU overflow this cycle
//   stall, flush         hold PC + IF/ID / squash IF/ID
//   ex_aluop, ex_alu_in_b, ex_br {bex,blt,jr,bne}, ex_jmp {jal,j}
//                        EX-stage controls
//   mem_wren             MEM store enable
//   wb_we, wb_rwd, wb_exc, wb_dst
//                        WB write enable, memory-data select, exception
//                        write flag, destination register
//   fwd_a, fwd_b         (FWD_EN only) 00 regfile, 01 EX/MEM, 10 MEM/WB
// -----------------------------------------------------------------------------
module pipeline_control_unit #(
    parameter int OPW     = 5,
    parameter int REGW    = 5,
    parameter int RSTATUS = 30,
    parameter int LINK    = 31
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            id_valid,
    input  logic [OPW-1:0]  opcode,
    input  logic [OPW-1:0]  raw_aluop,
    input  logic [REGW-1:0] rd,
    input  logic [REGW-1:0] rs,
    input  logic [REGW-1:0] rt,
    input  logic            branch_taken,
    input  logic            ex_ovf,
    output logic            stall,
    output logic            flush,
    output logic [OPW-1:0]  ex_aluop,
    output logic            ex_alu_in_b,
    output logic [3:0]      ex_br,
    output logic [1:0]      ex_jmp,
    output logic            mem_wren,
    output logic            wb_we,
    output logic            wb_rwd,
    output logic            wb_exc,
    output logic [REGW-1:0] wb_dst
`ifdef FWD_EN
    ,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b
`endif
);

    localparam logic [OPW-1:0] OP_RTYPE = OPW'(5'b00000);
    localparam logic [OPW-1:0] OP_J     = OPW'(5'b00001);
    localparam logic [OPW-1:0] OP_BNE   = OPW'(5'b00010);
    localparam logic [OPW-1:0] OP_JAL   = OPW'(5'b00011);
    localparam logic [OPW-1:0] OP_JR    = OPW'(5'b00100);
    localparam logic [OPW-1:0] OP_ADDI  = OPW'(5'b00101);
    localparam logic [OPW-1:0] OP_BLT   = OPW'(5'b00110);
    localparam logic [OPW-1:0] OP_SW    = OPW'(5'b00111);
    localparam logic [OPW-1:0] OP_LW    = OPW'(5'b01000);
    localparam logic [OPW-1:0] OP_SETX  = OPW'(5'b10101);
    localparam logic [OPW-1:0] OP_BEX   = OPW'(5'b10110);

    localparam logic [OPW-1:0] ALU_SUB  = OPW'(1);
    localparam logic [OPW-1:0] ALU_MAX  = OPW'(5);   // add..sra are 0..5

    localparam logic [REGW-1:0] REG_STATUS = REGW'(RSTATUS);
    localparam logic [REGW-1:0] REG_LINK   = REGW'(LINK);

    typedef struct packed {
        logic            valid;
        logic [OPW-1:0]  aluop;
        logic            alu_in_b;
        logic [3:0]      br;
        logic [1:0]      jmp;
        logic            exp;      // overflow-checked operation
        logic            we;
        logic            rwd;      // load: WB takes memory data
        logic            wren;
        logic [REGW-1:0] dst;
    } ex_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            rwd;
        logic            exc;
        logic            wren;
        logic [REGW-1:0] dst;
    } mem_ctrl_t;

    typedef struct packed {
        logic            valid;
        logic            we;
        logic            rwd;
        logic            exc;
        logic [REGW-1:0] dst;
    } wb_ctrl_t;

    ex_ctrl_t  id_ctrl;
    ex_ctrl_t  ex_d,  ex_q;
    mem_ctrl_t mem_d, mem_q;
    wb_ctrl_t  wb_d,  wb_q;

    // Source registers read by the ID instruction; 0 means "no source",
    // which is harmless because register 0 never creates a hazard.
    logic [1:0][REGW-1:0] id_src;

    // ---------------------------------------------------------------- decode
    always_comb begin
        id_ctrl       = '0;
        id_src        = '0;
        id_ctrl.valid = id_valid;
        if (id_valid) begin
            case (opcode)
                OP_RTYPE: begin
                    // Undefined ALU ops fall through as a NOP.
                    if (raw_aluop <= ALU_MAX) begin
                        id_ctrl.aluop = raw_aluop;
                        id_ctrl.we    = 1'b1;
                        id_ctrl.dst   = rd;
                        id_ctrl.exp   = (raw_aluop <= ALU_SUB);
                        id_src[0]     = rs;
                        id_src[1]     = rt;
                    end
                end
                OP_ADDI: begin
                    id_ctrl.alu_in_b = 1'b1;
                    id_ctrl.we       = 1'b1;
                    id_ctrl.dst      = rd;
                    id_ctrl.exp      = 1'b1;
                    id_src[0]        = rs;
                end
                OP_LW: begin
                    id_ctrl.alu_in_b = 1'b1;
                    id_ctrl.we       = 1'b1;
                    id_ctrl.rwd      = 1'b1;
                    id_ctrl.dst      = rd;
                    id_src[0]        = rs;
                end
                OP_SW: begin
                    id_ctrl.alu_in_b = 1'b1;
                    id_ctrl.wren     = 1'b1;
                    id_src[0]        = rs;
                    id_src[1]        = rd;   // store data
                end
                OP_BNE: begin
                    id_ctrl.br[0] = 1'b1;
                    id_src[0]     = rd;
                    id_src[1]     = rs;
                end
                OP_JR: begin
                    id_ctrl.br[1] = 1'b1;
                    id_src[0]     = rd;
                end
                OP_BLT: begin
                    id_ctrl.br[2] = 1'b1;
                    id_src[0]     = rd;
                    id_src[1]     = rs;
                end
                OP_BEX: begin
                    id_ctrl.br[3] = 1'b1;
                    id_src[0]     = REG_STATUS;
                end
                OP_J: begin
                    id_ctrl.jmp[0] = 1'b1;
                end
                OP_JAL: begin
                    id_ctrl.jmp[1] = 1'b1;
                    id_ctrl.we     = 1'b1;
                    id_ctrl.dst    = REG_LINK;
                end
                OP_SETX: begin
                    id_ctrl.we  = 1'b1;
                    id_ctrl.dst = REG_STATUS;
                end
                default: ;
            endcase
            // Writes to register 0 are discarded.
            if (id_ctrl.dst == '0) begin
                id_ctrl.we = 1'b0;
            end
        end
    end

    // --------------------------------------------------------------- hazards
    logic [1:0] hit_ex;
    logic [1:0] hit_mem;
    logic       stall_req;

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_src_hit
            assign hit_ex[gi]  = ex_q.valid && ex_q.we && (ex_q.dst != '0) &&
                                 (ex_q.dst == id_src[gi]);
            assign hit_mem[gi] = mem_q.valid && mem_q.we && (mem_q.dst != '0) &&
                                 (mem_q.dst == id_src[gi]);
        end
    endgenerate

`ifdef FWD_EN
    // With forwarding only a load in EX cannot supply its result in time.
    logic load_use;
    assign load_use  = ex_q.rwd && (|hit_ex);
    assign stall_req = id_valid && load_use;
`else
    // Without forwarding wait until the producer reaches WB; the register
    // file writes before it reads, so a WB match is already safe.
    assign stall_req = id_valid && ((|hit_ex) || (|hit_mem));
`endif

    // A taken branch squashes the ID instruction, so there is nothing left
    // to hold: flush wins over stall.
    assign flush = branch_taken && reset_n;
    assign stall = stall_req && !flush;

    // ------------------------------------------------------ stage next-state
    always_comb begin
        ex_d = id_ctrl;
        if (stall_req || flush) begin
            ex_d = '0;
        end
    end

    always_comb begin
        mem_d.valid = ex_q.valid;
        mem_d.we    = ex_q.we;
        mem_d.rwd   = ex_q.rwd;
        mem_d.exc   = 1'b0;
        mem_d.wren  = ex_q.wren;
        mem_d.dst   = ex_q.dst;
        // Overflow redirects the write to the status register.
        if (ex_ovf && ex_q.exp && ex_q.valid) begin
            mem_d.dst = REG_STATUS;
            mem_d.we  = 1'b1;
            mem_d.exc = 1'b1;
        end
    end

    always_comb begin
        wb_d.valid = mem_q.valid;
        wb_d.we    = mem_q.we;
        wb_d.rwd   = mem_q.rwd;
        wb_d.exc   = mem_q.exc;
        wb_d.dst   = mem_q.dst;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_q  <= '0;
            mem_q <= '0;
            wb_q  <= '0;
        end else begin
            ex_q  <= ex_d;
            mem_q <= mem_d;
            wb_q  <= wb_d;
        end
    end

    // --------------------------------------------------------------- outputs
    assign ex_aluop    = ex_q.aluop;
    assign ex_alu_in_b = ex_q.alu_in_b;
    assign ex_br       = ex_q.br;
    assign ex_jmp      = ex_q.jmp;
    assign mem_wren    = mem_q.valid && mem_q.wren;
    assign wb_we       = wb_q.valid && wb_q.we;
    assign wb_rwd      = wb_q.rwd;
    assign wb_exc      = wb_q.exc;
    assign wb_dst      = wb_q.dst;

`ifdef FWD_EN
    // ----------------------------------------------------------- forwarding
    logic [1:0][REGW-1:0] ex_src_d, ex_src_q;
    logic [1:0][1:0]      fwd_sel;

    always_comb begin
        ex_src_d = id_src;
        if (stall_req || flush) begin
            ex_src_d = '0;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            ex_src_q <= '0;
        end else begin
            ex_src_q <= ex_src_d;
        end
    end

    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_fwd
            logic from_mem;
            logic from_wb;
            assign from_mem = mem_q.valid && mem_q.we && (mem_q.dst != '0) &&
                              (mem_q.dst == ex_src_q[gi]);
            assign from_wb  = wb_q.valid && wb_q.we && (wb_q.dst != '0) &&
                              (wb_q.dst == ex_src_q[gi]);
            // The younger result in EX/MEM takes priority.
            assign fwd_sel[gi] = from_mem ? 2'b01 : (from_wb ? 2'b10 : 2'b00);
        end
    endgenerate

    assign fwd_a = fwd_sel[0];
    assign fwd_b = fwd_sel[1];
`endif

endmodule

// File: tb/tb_pipeline_control_unit.sv
// -----------------------------------------------------------------------------
// tb_pipeline_control_unit
//
// Self-checking bench for pipeline_control_unit in its default build
// (forwarding disabled). A reference model keeps one record per pipeline
// stage, decoded from the instruction-class rules, and every clock the DUT
// outputs are compared against it. Directed scenarios cover reset, latency,
// data hazards, flush priority, overflow redirection and the r0/jal/setx
// destinations; a randomized run follows.
// -----------------------------------------------------------------------------
module tb_pipeline_control_unit;

    localparam int C_NOP = 0, C_ADDSUB = 1, C_ALU = 2, C_ADDI = 3, C_LW = 4,
                   C_SW = 5, C_BNE = 6, C_J = 7, C_JAL = 8, C_JR = 9,
                   C_BLT = 10, C_BEX = 11, C_SETX = 12;

    logic       clock = 1'b0;
    logic       reset_n;
    logic       id_valid;
    logic [4:0] opcode;
    logic [4:0] raw_aluop;
    logic [4:0] rd;
    logic [4:0] rs;
    logic [4:0] rt;
    logic       branch_taken;
    logic       ex_ovf;
    logic       stall;
    logic       flush;
    logic [4:0] ex_aluop;
    logic       ex_alu_in_b;
    logic [3:0] ex_br;
    logic [1:0] ex_jmp;
    logic       mem_wren;
    logic       wb_we;
    logic       wb_rwd;
    logic       wb_exc;
    logic [4:0] wb_dst;

    always #5 clock = ~clock;

    pipeline_control_unit dut (
        .clock        (clock),
        .reset_n      (reset_n),
        .id_valid     (id_valid),
        .opcode       (opcode),
        .raw_aluop    (raw_aluop),
        .rd           (rd),
        .rs           (rs),
        .rt           (rt),
        .branch_taken (branch_taken),
        .ex_ovf       (ex_ovf),
        .stall        (stall),
        .flush        (flush),
        .ex_aluop     (ex_aluop),
        .ex_alu_in_b  (ex_alu_in_b),
        .ex_br        (ex_br),
        .ex_jmp       (ex_jmp),
        .mem_wren     (mem_wren),
        .wb_we        (wb_we),
        .wb_rwd       (wb_rwd),
        .wb_exc       (wb_exc),
        .wb_dst       (wb_dst)
    );

    // One in-flight instruction as the model sees it.
    typedef struct {
        bit valid;
        int aluop;
        bit alu_in_b;
        int br;
        int jmp;
        bit exp;
        bit we;
        bit rwd;
        bit wren;
        bit exc;
        int dst;
    } ins_t;

    ins_t m_ex, m_mem, m_wb;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    bit   last_dut_stall;
    bit   last_exp_stall;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic int classify(input int op, input int raw);
        case (op)
            0:       return (raw <= 1) ? C_ADDSUB : ((raw <= 5) ? C_ALU : C_NOP);
            5:       return C_ADDI;
            8:       return C_LW;
            7:       return C_SW;
            2:       return C_BNE;
            1:       return C_J;
            3:       return C_JAL;
            4:       return C_JR;
            6:       return C_BLT;
            22:      return C_BEX;
            21:      return C_SETX;
            default: return C_NOP;
        endcase
    endfunction

    function automatic ins_t empty_ins();
        ins_t r;
        r = '{default: 0};
        return r;
    endfunction

    function automatic ins_t decode(input bit v, input int op, input int raw, input int d);
        ins_t r;
        int   c;
        r = empty_ins();
        if (!v) return r;
        r.valid = 1;
        c = classify(op, raw);
        if (c == C_ADDSUB || c == C_ALU) begin
            r.aluop = raw; r.we = 1; r.dst = d; r.exp = (c == C_ADDSUB);
        end else if (c == C_ADDI) begin
            r.alu_in_b = 1; r.we = 1; r.dst = d; r.exp = 1;
        end else if (c == C_LW) begin
            r.alu_in_b = 1; r.we = 1; r.rwd = 1; r.dst = d;
        end else if (c == C_SW) begin
            r.alu_in_b = 1; r.wren = 1;
        end else if (c == C_BNE) r.br = 1;
        else if (c == C_JR)   r.br = 2;
        else if (c == C_BLT)  r.br = 4;
        else if (c == C_BEX)  r.br = 8;
        else if (c == C_J)    r.jmp = 1;
        else if (c == C_JAL) begin
            r.jmp = 2; r.we = 1; r.dst = 31;
        end else if (c == C_SETX) begin
            r.we = 1; r.dst = 30;
        end
        if (r.dst == 0) r.we = 0;
        return r;
    endfunction

    // Registers read by an instruction class; 0 stands for "none".
    task automatic srcs(input int c, input int d, input int s, input int t,
                        output int sa, output int sb);
        sa = 0;
        sb = 0;
        if (c == C_ADDSUB || c == C_ALU) begin sa = s; sb = t; end
        else if (c == C_ADDI || c == C_LW) sa = s;
        else if (c == C_SW) begin sa = s; sb = d; end
        else if (c == C_BNE || c == C_BLT) begin sa = d; sb = s; end
        else if (c == C_JR)  sa = d;
        else if (c == C_BEX) sa = 30;
    endtask

    function automatic bit hz(input ins_t p, input int sa, input int sb);
        return p.we && p.dst != 0 && ((sa != 0 && p.dst == sa) || (sb != 0 && p.dst == sb));
    endfunction

    task automatic check_regs();
        chk("ex_aluop",    32'(ex_aluop),    32'(m_ex.aluop));
        chk("ex_alu_in_b", 32'(ex_alu_in_b), 32'(m_ex.alu_in_b));
        chk("ex_br",       32'(ex_br),       32'(m_ex.br));
        chk("ex_jmp",      32'(ex_jmp),      32'(m_ex.jmp));
        chk("mem_wren",    32'(mem_wren),    32'(m_mem.wren));
        chk("wb_we",       32'(wb_we),       32'(m_wb.we));
        chk("wb_rwd",      32'(wb_rwd),      32'(m_wb.rwd));
        chk("wb_exc",      32'(wb_exc),      32'(m_wb.exc));
        chk("wb_dst",      32'(wb_dst),      32'(m_wb.dst));
    endtask

    task automatic clear_model();
        m_ex  = empty_ins();
        m_mem = empty_ins();
        m_wb  = empty_ins();
    endtask

    // One clock: inputs are already driven (at the falling edge). Compare,
    // let the rising edge happen, advance the model, return at next fall.
    task automatic cycle();
        int sa, sb, c;
        bit es, ef;
        #1;
        c = classify(int'(opcode), int'(raw_aluop));
        srcs(c, int'(rd), int'(rs), int'(rt), sa, sb);
        ef = branch_taken && reset_n;
        es = reset_n && id_valid && !branch_taken && (hz(m_ex, sa, sb) || hz(m_mem, sa, sb));
        chk("stall", 32'(stall), 32'(es));
        chk("flush", 32'(flush), 32'(ef));
        check_regs();
        last_dut_stall = stall;
        last_exp_stall = es;
        $display("cyc %0d rst_n=%0b id_v=%0b op=%0d alu=%0d rd=%0d rs=%0d rt=%0d br_tk=%0b ovf=%0b | stall=%0b flush=%0b ex_aluop=%0d ex_br=%0h mem_wren=%0b wb_we=%0b wb_dst=%0d wb_exc=%0b",
                 cyc, reset_n, id_valid, opcode, raw_aluop, rd, rs, rt, branch_taken, ex_ovf,
                 stall, flush, ex_aluop, ex_br, mem_wren, wb_we, wb_dst, wb_exc);
        @(posedge clock);
        if (!reset_n) begin
            clear_model();
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            if (ex_ovf && m_ex.exp && m_ex.valid) begin
                m_mem.dst = 30;
                m_mem.we  = 1;
                m_mem.exc = 1;
            end
            if (es || ef) m_ex = empty_ins();
            else          m_ex = decode(id_valid, int'(opcode), int'(raw_aluop), int'(rd));
        end
        @(negedge clock);
        cyc++;
    endtask

    task automatic set_ins(input int op, input int raw, input int d, input int s, input int t);
        id_valid  = 1'b1;
        opcode    = 5'(op);
        raw_aluop = 5'(raw);
        rd        = 5'(d);
        rs        = 5'(s);
        rt        = 5'(t);
    endtask

    task automatic set_nop();
        id_valid  = 1'b0;
        opcode    = 5'd0;
        raw_aluop = 5'd0;
        rd        = 5'd0;
        rs        = 5'd0;
        rt        = 5'd0;
    endtask

    function automatic int pick_reg();
        case ($urandom_range(0, 5))
            0:       return 0;
            1:       return 1;
            2:       return 2;
            3:       return 3;
            4:       return 30;
            default: return 31;
        endcase
    endfunction

    initial begin
        int n_stall;
        int edges;
        int ops[12];
        ops = '{0, 5, 8, 7, 2, 1, 3, 4, 6, 22, 21, 0};
        clear_model();
        reset_n      = 1'b0;
        branch_taken = 1'b0;
        ex_ovf       = 1'b0;
        last_dut_stall = 1'b0;
        last_exp_stall = 1'b0;

        // Reset held with an addi waiting in ID: nothing moves.
        set_ins(5, 0, 5, 1, 0);
        @(negedge clock);
        repeat (3) cycle();
        chk("rst_wb_we", 32'(wb_we), 32'd0);
        chk("rst_stall", 32'(stall), 32'd0);

        // Release: addi r5 decoded once, wb_we rises on the third edge.
        reset_n = 1'b1;
        cycle();
        set_nop();
        cycle();
        chk("lat_wb_we_edge2", 32'(wb_we), 32'd0);
        cycle();
        chk("lat_wb_we_edge3", 32'(wb_we), 32'd1);
        chk("lat_wb_dst_edge3", 32'(wb_dst), 32'd5);
        repeat (2) cycle();

        // Load-use: lw r3 then add r4,r3,r5 (no forwarding: 2 stall cycles).
        set_ins(8, 0, 3, 1, 0);
        cycle();
        set_ins(0, 0, 4, 3, 5);
        n_stall = 0;
        edges = 0;
        do begin
            cycle();
            edges++;
            if (last_dut_stall) begin
                n_stall++;
                chk("lu_bubble_aluop", 32'(ex_aluop), 32'd0);
                chk("lu_bubble_wren",  32'(mem_wren), 32'd0);
            end
        end while (last_dut_stall && edges < 10);
        chk("lu_stall_cycles", 32'(n_stall), 32'd2);
        set_nop();
        while (!(wb_we === 1'b1 && wb_dst === 5'd4) && edges < 12) begin
            cycle();
            edges++;
        end
        chk("lu_wb_edges", 32'(edges), 32'd5);
        repeat (2) cycle();

        // Flush beats stall: lw r9 in MEM, bne in EX, add reading r9 in ID.
        set_ins(8, 0, 9, 1, 0);
        cycle();
        set_ins(2, 0, 1, 2, 0);
        cycle();
        set_ins(0, 0, 10, 9, 9);
        branch_taken = 1'b1;
        #1;
        chk("br_flush", 32'(flush), 32'd1);
        chk("br_stall", 32'(stall), 32'd0);
        cycle();
        branch_taken = 1'b0;
        chk("br_bubble_br",    32'(ex_br),    32'd0);
        chk("br_bubble_aluop", 32'(ex_aluop), 32'd0);
        set_nop();
        repeat (3) cycle();

        // Overflow redirection: add r7 with and without ex_ovf.
        for (int k = 0; k < 2; k++) begin
            set_ins(0, 0, 7, 1, 2);
            cycle();
            set_nop();
            ex_ovf = (k == 0);
            cycle();
            ex_ovf = 1'b0;
            cycle();
            chk("ovf_wb_we",  32'(wb_we),  32'd1);
            chk("ovf_wb_dst", 32'(wb_dst), (k == 0) ? 32'd30 : 32'd7);
            chk("ovf_wb_exc", 32'(wb_exc), (k == 0) ? 32'd1 : 32'd0);
        end
        repeat (2) cycle();

        // r0 / consumer of r0 / jal / setx back to back.
        set_ins(0, 0, 0, 1, 2);
        cycle();
        set_ins(0, 0, 1, 0, 0);
        #1;
        chk("r0_consumer_stall", 32'(stall), 32'd0);
        cycle();
        set_ins(3, 0, 0, 0, 0);
        cycle();
        chk("r0_wb_we", 32'(wb_we), 32'd0);
        set_ins(21, 0, 0, 0, 0);
        cycle();
        chk("r1_wb_dst", 32'(wb_dst), 32'd1);
        set_nop();
        cycle();
        chk("jal_wb_dst", 32'(wb_dst), 32'd31);
        chk("jal_wb_we",  32'(wb_we),  32'd1);
        cycle();
        chk("setx_wb_dst", 32'(wb_dst), 32'd30);

        // Asynchronous reset with a full pipeline.
        set_ins(5, 0, 5, 1, 0);
        cycle();
        set_ins(5, 0, 6, 2, 0);
        cycle();
        cycle();
        #2;
        reset_n = 1'b0;
        #1;
        clear_model();
        chk("arst_alu_in_b", 32'(ex_alu_in_b), 32'd0);
        check_regs();
        cycle();
        reset_n = 1'b1;
        set_nop();
        repeat (3) cycle();

        // Randomized traffic; IF/ID is held while the model expects a stall.
        for (int n = 0; n < 350; n++) begin
            if (!last_exp_stall) begin
                if ($urandom_range(0, 7) == 0) begin
                    set_nop();
                end else begin
                    set_ins(($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 31))
                                                        : ops[$urandom_range(0, 11)],
                            int'($urandom_range(0, 7)), pick_reg(), pick_reg(), pick_reg());
                end
            end
            branch_taken = ($urandom_range(0, 7) == 0);
            ex_ovf       = ($urandom_range(0, 3) == 0);
            cycle();
        end
        branch_taken = 1'b0;
        ex_ovf       = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
